fd_top: RTL and testbench
=========================

FD_TOP -- requirements
Module: fd_top

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, bit width of event value.
REQ-002 SHALL have parameter TODO_WINDOW_FIFO_DEPTH, default 128, entries in pending-window FIFO (power of two, >=4).
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-high (rst_n=1 resets).
REQ-005 SHALL have port in_event_valid_0  in  1  event present this cycle.
REQ-006 SHALL have port in_event_value_0  in  DATA_WIDTH  event value.
REQ-007 SHALL have port in_event_addr_0  in  16  pixel address, [15:8]=row, [7:0]=col (256x256 map).
REQ-008 SHALL have port ready_for_new_feature  in  1  downstream accepts result.
REQ-009 SHALL have port event_req  out  1  request next event from dispatcher.
REQ-010 SHALL have port out_isfeature  out  1  processed pixel is a feature.
REQ-011 SHALL have port out_feature_addr  out  16  address of processed pixel.
REQ-012 SHALL have port out_feature_valid  out  1  result valid.

Function
REQ-013 SHALL hold a 65536 x DATA_WIDTH value map, initialised to 0 at configuration, not cleared by reset.
REQ-014 An event (in_event_valid_0=1, FIFO not full) SHALL write value to map[addr] and push addr into FIFO in the same cycle.
REQ-015 An event arriving while FIFO full SHALL be dropped entirely (no map write, no push).
REQ-016 event_req SHALL be registered: 1 when FIFO occupancy < DEPTH-2 and not in reset, else 0.
REQ-017 Map read port SHALL have 1-cycle latency, read-first on same-address write collision.
REQ-018 FSM states SHALL be IDLE, READ, EVAL, OUT; reset state IDLE.
REQ-019 IDLE: if FIFO non-empty, pop head into centre register and go to READ; else stay.
REQ-020 READ SHALL issue 9 reads on 9 consecutive cycles: centre, then (-1,-1),(-1,0),(-1,+1),(0,-1),(0,+1),(+1,-1),(+1,0),(+1,+1) as (drow,dcol).
REQ-021 Neighbours with row or col outside 0..255 SHALL read as 0 (no wrap-around).
REQ-022 After last read data returns, go to EVAL; feature = centre>0 AND centre strictly greater than all 8 neighbours (unsigned).
REQ-023 EVAL -> OUT registers out_isfeature, out_feature_addr, and out_feature_valid=1.
REQ-024 OUT SHALL hold outputs stable until a cycle with ready_for_new_feature=1, then clear out_feature_valid and return to IDLE.
REQ-025 With ready held 1, out_feature_valid SHALL rise 11 cycles after the pop edge and last 1 cycle.
REQ-026 Event intake SHALL continue in every FSM state, including simultaneous push and pop (occupancy unchanged).

Reset
REQ-027 During reset: FIFO emptied, FSM=IDLE, event_req=0, out_feature_valid=0, out_isfeature=0, out_feature_addr=0.
REQ-028 Reset mid-operation SHALL abandon the in-progress window with no output; map contents retained.

Configuration
REQ-029 Macro FD_SUPPRESS_NONFEATURE_EN: when defined, EVAL with feature=0 returns to IDLE without entering OUT (only features reported); when undefined, every popped address is reported with out_isfeature indicating result.

Verification
REQ-030 Single event addr 0x1010 value 5 on empty map -> valid, isfeature=1, addr 0x1010, 11 cycles after pop.
REQ-031 Events 0x1011 value 7 then 0x1010 value 5 -> second result isfeature=0 (neighbour 7>=5); first isfeature=1.
REQ-032 Event addr 0x0000 value 1 -> isfeature=1 (out-of-range neighbours read 0); event value 0 anywhere -> isfeature=0.
REQ-033 Hold ready_for_new_feature=0 for 20 cycles -> outputs stable, valid held; release -> next result follows.
REQ-034 Burst 200 events, ready=0 -> event_req falls at occupancy DEPTH-2, no FIFO overflow, all accepted events reported once after ready=1.
REQ-035 Assert reset during READ -> outputs 0, FIFO empty, map retains written values (re-posting same address gives identical result).

Source files
------------

// File: rtl/fd_top.sv
// Feature detector: events update a 256x256 value map and queue their address.
// Each queued address gets a 3x3 window read. The centre is reported as a feature
// when it is nonzero and strictly greater than all 8 neighbours.
// Optional build macro: FD_SUPPRESS_NONFEATURE_EN (report only feature pixels).
module fd_top #(
  parameter int unsigned DATA_WIDTH             = 4,
  parameter int unsigned TODO_WINDOW_FIFO_DEPTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_event_valid_0,
  input  logic [DATA_WIDTH-1:0] in_event_value_0,
  input  logic [15:0]           in_event_addr_0,
  input  logic                  ready_for_new_feature,
  output logic                  event_req,
  output logic                  out_isfeature,
  output logic [15:0]           out_feature_addr,
  output logic                  out_feature_valid
);

  localparam int unsigned PtrW = $clog2(TODO_WINDOW_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FifoFull = CntW'(TODO_WINDOW_FIFO_DEPTH);
  localparam logic [CntW-1:0] ReqLimit = CntW'(TODO_WINDOW_FIFO_DEPTH - 2);
  localparam logic [3:0] LastCnt = 4'd9;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StEval = 2'd2;
  localparam logic [1:0] StOut  = 2'd3;

  // Note: rst_n is an active-high reset despite its name.

  // ---------------- pending-window FIFO ----------------
  logic [15:0]     fifo_mem [TODO_WINDOW_FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            fifo_full, fifo_empty, push, pop;
  logic            event_req_q;
  logic [1:0]      state_q;

  assign fifo_full  = (count_q == FifoFull);
  assign fifo_empty = (count_q == '0);
  // Fullness is judged before this cycle's pop, so a full FIFO drops the event.
  assign push = in_event_valid_0 && !fifo_full && !rst_n;
  assign pop  = (state_q == StIdle) && !fifo_empty && !rst_n;

  // Next occupancy; a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // FIFO storage write (no reset needed on data)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= in_event_addr_0;
    end
  end

  // FIFO pointers, occupancy and the registered request flag
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      event_req_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q     <= count_d;
      event_req_q <= (count_d < ReqLimit);
    end
  end

  assign event_req = event_req_q;

  // ---------------- value map ----------------
  // Contents come from power-up configuration (all zero) and survive reset.
  logic [DATA_WIDTH-1:0] map_mem [65536];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rd_oob_q;
  logic [15:0]           rd_addr;
  logic                  rd_oob;

  // Map write on accepted events, 1-cycle read; the read sees the old value on collision
  always_ff @(posedge clk) begin
    if (push) begin
      map_mem[in_event_addr_0] <= in_event_value_0;
    end
    rdata_q  <= map_mem[rd_addr];
    rd_oob_q <= rd_oob;
  end

  // ---------------- window walk ----------------
  logic [15:0]           centre_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] centre_val_q, nb_max_q, cap_val;
  logic                  out_valid_q, out_isf_q;
  logic [15:0]           out_addr_q;
  logic signed [9:0]     drow, dcol, nrow, ncol;
  logic                  is_feat;

  // Offset for the read issued this cycle: centre first, then raster order
  always_comb begin
    drow = '0;
    dcol = '0;
    case (cnt_q)
      4'd1:    begin drow = -10'sd1; dcol = -10'sd1; end
      4'd2:    begin drow = -10'sd1; dcol =  10'sd0; end
      4'd3:    begin drow = -10'sd1; dcol =  10'sd1; end
      4'd4:    begin drow =  10'sd0; dcol = -10'sd1; end
      4'd5:    begin drow =  10'sd0; dcol =  10'sd1; end
      4'd6:    begin drow =  10'sd1; dcol = -10'sd1; end
      4'd7:    begin drow =  10'sd1; dcol =  10'sd0; end
      4'd8:    begin drow =  10'sd1; dcol =  10'sd1; end
      default: begin drow =  10'sd0; dcol =  10'sd0; end
    endcase
  end

  assign nrow    = $signed({2'b00, centre_q[15:8]}) + drow;
  assign ncol    = $signed({2'b00, centre_q[7:0]}) + dcol;
  // Bit 9 set means negative, bit 8 set means beyond 255: both lie off the map
  assign rd_oob  = nrow[9] | nrow[8] | ncol[9] | ncol[8];
  assign rd_addr = {nrow[7:0], ncol[7:0]};
  assign cap_val = rd_oob_q ? '0 : rdata_q;
  assign is_feat = (centre_val_q != '0) && (centre_val_q > nb_max_q);

  // Control FSM: pop, issue 9 reads plus a drain cycle, evaluate, hold the result
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      centre_q     <= '0;
      centre_val_q <= '0;
      nb_max_q     <= '0;
      out_valid_q  <= 1'b0;
      out_isf_q    <= 1'b0;
      out_addr_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            centre_q <= fifo_mem[rd_ptr_q];
            cnt_q    <= '0;
            state_q  <= StRead;
          end
        end
        StRead: begin
          cnt_q <= cnt_q + 4'd1;
          // Data for the read issued in the previous cycle arrives now
          if (cnt_q == 4'd1) begin
            centre_val_q <= cap_val;
            nb_max_q     <= '0;
          end else if (cnt_q != 4'd0 && cap_val > nb_max_q) begin
            nb_max_q <= cap_val;
          end
          if (cnt_q == LastCnt) begin
            state_q <= StEval;
          end
        end
        StEval: begin
`ifdef FD_SUPPRESS_NONFEATURE_EN
          if (is_feat) begin
            out_isf_q   <= 1'b1;
            out_addr_q  <= centre_q;
            out_valid_q <= 1'b1;
            state_q     <= StOut;
          end else begin
            state_q <= StIdle;
          end
`else
          out_isf_q   <= is_feat;
          out_addr_q  <= centre_q;
          out_valid_q <= 1'b1;
          state_q     <= StOut;
`endif
        end
        StOut: begin
          if (ready_for_new_feature) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_feature_valid = out_valid_q;
  assign out_isfeature     = out_isf_q;
  assign out_feature_addr  = out_addr_q;

endmodule

// File: tb/tb_fd_top.sv
// Directed bench for fd_top with a scoreboard of expected {isfeature, addr} results.
module tb_fd_top;

  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_event_valid_0;
  logic [DW-1:0] in_event_value_0;
  logic [15:0]   in_event_addr_0;
  logic          ready_for_new_feature;
  logic          event_req;
  logic          out_isfeature;
  logic [15:0]   out_feature_addr;
  logic          out_feature_valid;

  fd_top #(
    .DATA_WIDTH             (DW),
    .TODO_WINDOW_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .in_event_valid_0      (in_event_valid_0),
    .in_event_value_0      (in_event_value_0),
    .in_event_addr_0       (in_event_addr_0),
    .ready_for_new_feature (ready_for_new_feature),
    .event_req             (event_req),
    .out_isfeature         (out_isfeature),
    .out_feature_addr      (out_feature_addr),
    .out_feature_valid     (out_feature_valid)
  );

  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [16:0]   sb_q [$];
  logic [15:0]   acc_q [$];
  logic [DW-1:0] model_map [65536];
  logic [16:0]   mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] exp_result(input logic [15:0] a);
    logic [DW-1:0] cv;
    logic          feat;
    int            r, c, nr, nc;
    cv   = model_map[a];
    feat = (cv != '0);
    r    = int'(a[15:8]);
    c    = int'(a[7:0]);
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nr = r + dr;
        nc = c + dc;
        if ((dr != 0 || dc != 0) && nr >= 0 && nr <= 255 && nc >= 0 && nc <= 255) begin
          if (model_map[16'(nr * 256 + nc)] >= cv) feat = 1'b0;
        end
      end
    end
    return {feat, a};
  endfunction

  function automatic logic [15:0] addr_of(input int k);
    logic [7:0] r, c;
    r = 8'(128 + 3 * (k / 64));
    c = 8'(3 * (k % 64));
    return {r, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [DW-1:0] v);
    in_event_valid_0 = 1'b1;
    in_event_addr_0  = a;
    in_event_value_0 = v;
    tick();
    in_event_valid_0 = 1'b0;
    model_map[a]     = v;
  endtask

  task automatic expect_for(input logic [15:0] a);
    sb_q.push_back(exp_result(a));
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, sb_q.size(), 0);
    sb_q.delete();
    repeat (3) tick();
  endtask

  // Result monitor: each accepted handshake consumes one scoreboard entry
  always @(negedge clk) begin
    if (out_feature_valid === 1'b1 && ready_for_new_feature === 1'b1) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_result observed %0h expected none", out_feature_addr);
      end
      if (sb_q.size() != 0) begin
        mon_exp = sb_q.pop_front();
        checks++;
        assert ({out_isfeature, out_feature_addr} === mon_exp) else begin
          errors++;
          $error("FAIL result observed %0h expected %0h",
                 {out_isfeature, out_feature_addr}, mon_exp);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  occ;
    logic seen;
    foreach (model_map[i]) model_map[i] = '0;
    rst_n                 = 1'b1;
    in_event_valid_0      = 1'b0;
    in_event_value_0      = '0;
    in_event_addr_0       = '0;
    ready_for_new_feature = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_event_req", event_req, 0);
    chk("rst_valid", out_feature_valid, 0);
    chk("rst_isfeature", out_isfeature, 0);
    chk("rst_addr", out_feature_addr, 0);
    rst_n = 1'b0;
    tick();
    chk("event_req_after_reset", event_req, 1);
    repeat (2) tick();

    // Single event: 1 cycle to pop, then 11 cycles to valid, valid for 1 cycle
    send(16'h1010, 4'd5);
    expect_for(16'h1010);
    n = 0;
    while (out_feature_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("latency_edges_after_push", n, 12);
    tick();
    chk("valid_one_cycle", out_feature_valid, 0);
    wait_drain(50, "drain_single");

    // Neighbour comparison: 7 beats 5, 5 does not beat 7
    send(16'h1011, 4'd7);
    send(16'h1010, 4'd5);
    expect_for(16'h1011);
    expect_for(16'h1010);
    wait_drain(100, "drain_pair");

    // Map edges, zero value, and no column wrap-around
    send(16'h0000, 4'd1);
    send(16'hFFFF, 4'd2);
    send(16'h5050, 4'd0);
    send(16'h3000, 4'd9);
    send(16'h30FF, 4'd3);
    expect_for(16'h0000);
    expect_for(16'hFFFF);
    expect_for(16'h5050);
    expect_for(16'h3000);
    expect_for(16'h30FF);
    wait_drain(200, "drain_edges");

    // Back-pressure: result must stay stable while ready is low
    ready_for_new_feature = 1'b0;
    send(16'h6060, 4'd4);
    send(16'h6070, 4'd0);
    expect_for(16'h6060);
    expect_for(16'h6070);
    n = 0;
    while (out_feature_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      chk("hold_valid", out_feature_valid, 1);
      chk("hold_result", {out_isfeature, out_feature_addr}, sb_q[0]);
      tick();
    end
    ready_for_new_feature = 1'b1;
    wait_drain(100, "drain_hold");

    // Burst of 200 with ready low: first is popped, then FIFO fills to DEPTH
    ready_for_new_feature = 1'b0;
    for (int k = 0; k < 200; k++) begin
      in_event_valid_0 = 1'b1;
      in_event_addr_0  = addr_of(k);
      in_event_value_0 = DW'(k % 16);
      tick();
      if (k <= int'(DEPTH)) begin
        model_map[addr_of(k)] = DW'(k % 16);
        acc_q.push_back(addr_of(k));
      end
      occ = (k == 0) ? 1 : ((k < int'(DEPTH)) ? k : int'(DEPTH));
      chk("event_req_burst", event_req, (occ < int'(DEPTH) - 2) ? 1 : 0);
    end
    in_event_valid_0 = 1'b0;
    foreach (acc_q[i]) expect_for(acc_q[i]);
    ready_for_new_feature = 1'b1;
    wait_drain(5000, "drain_burst");
    chk("event_req_after_burst", event_req, 1);

    // A dropped event must not have written the map
    send(addr_of(150) + 16'd1, 4'd3);
    expect_for(addr_of(150) + 16'd1);
    wait_drain(50, "drain_dropped");

    // Reset while reading: window abandoned, FIFO emptied, map kept
    send(16'h2021, 4'd9);
    send(16'h2020, 4'd3);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_event_req", event_req, 0);
    chk("midrst_valid", out_feature_valid, 0);
    chk("midrst_isfeature", out_isfeature, 0);
    chk("midrst_addr", out_feature_addr, 0);
    tick();
    rst_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_feature_valid !== 1'b0) seen = 1'b1;
    end
    chk("no_output_after_reset", seen, 0);
    send(16'h2020, 4'd3);
    send(16'h2021, 4'd9);
    expect_for(16'h2020);
    expect_for(16'h2021);
    wait_drain(100, "drain_repost");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
